// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Brief    : Shared defaults, FSM state type and latency constants for the
//            SRAM RW port arbiter.
// Revision : 1.0
// ============================================================================
package sram_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 10;
   localparam int NUM_REQ        = 2;
   localparam int READ_LATENCY   = 2;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      SERVE = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_2
// Brief    : Two-way round-robin arbiter, combinational grant with a
//            registered priority pointer that advances on every grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic [1:0] i_valid,
   output logic [1:0] o_grant
);

   logic       r_ptr;
   logic [1:0] w_grant;

   always_comb begin
      w_grant = 2'b00;
      if (i_en) begin
         if (i_valid == 2'b11) w_grant = r_ptr ? 2'b10 : 2'b01;
         else                  w_grant = i_valid;
      end
   end

   assign o_grant = w_grant;

   // After granting requester 0 the pointer favours 1, and vice versa.
   always_ff @(posedge clk) begin
      if (rst)             r_ptr <= 1'b0;
      else if (|w_grant)   r_ptr <= w_grant[0];
   end

endmodule
`default_nettype wire

// File: rtl/sram_rw_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw_port_arbiter
// Brief    : Clears a single-port OpenRAM macro after reset, then shares its
//            port between two requesters with fixed-latency read responses.
// Revision : 1.0
// ============================================================================
module sram_rw_port_arbiter
   import sram_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter bit                    INIT_EN    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                          clk0,
   input  logic                          rst0,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          init_done,
   output logic                          csb0,
   output logic                          web0,
   output logic [ADDR_WIDTH-1:0]         addr0,
   output logic [DATA_WIDTH-1:0]         din0,
   input  logic [DATA_WIDTH-1:0]         dout0
);

   localparam int                RAM_DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_CNT_DONE = (ADDR_WIDTH+1)'(RAM_DEPTH);

   state_t                  r_state;
   logic [ADDR_WIDTH:0]     r_cnt;
   logic                    r_csb;
   logic                    r_web;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_din;
   logic                    r_init_done;
   logic [NUM_REQ-1:0]      r_rd_pipe [READ_LATENCY];
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;

   logic [NUM_REQ-1:0]      w_grant;
   logic                    w_sel;
   logic                    w_we;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_wdata;

   // Grants are suppressed while reset is asserted so req_ready reads 0.
   rr_arbiter_2 u_arb (
      .clk     (clk0),
      .rst     (rst0),
      .i_en    ((r_state == SERVE) && !rst0),
      .i_valid (req_valid),
      .o_grant (w_grant)
   );

   assign w_sel   = w_grant[1];
   assign w_we    = w_sel ? req_we[1] : req_we[0];
   assign w_addr  = w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
   assign w_wdata = w_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

   always_ff @(posedge clk0) begin
      if (rst0) begin
         r_state     <= INIT_EN ? INIT : SERVE;
         r_cnt       <= '0;
         r_csb       <= 1'b1;
         r_web       <= 1'b1;
         r_addr      <= '0;
         r_din       <= '0;
         r_init_done <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         for (int i = 0; i < READ_LATENCY; i++) r_rd_pipe[i] <= '0;
      end else begin
         // Read tags travel alongside the macro access; dout0 is valid at the last stage.
         r_rd_pipe[0] <= w_grant & ~req_we;
         for (int i = 1; i < READ_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
         r_rsp_valid <= r_rd_pipe[READ_LATENCY-1];
         if (|r_rd_pipe[READ_LATENCY-1]) r_rsp_rdata <= dout0;

         case (r_state)
            INIT: begin
               if (r_cnt == C_CNT_DONE) begin
                  r_state     <= SERVE;
                  r_init_done <= 1'b1;
                  r_csb       <= 1'b1;
                  r_web       <= 1'b1;
               end else begin
                  r_csb  <= 1'b0;
                  r_web  <= 1'b0;
                  r_addr <= r_cnt[ADDR_WIDTH-1:0];
                  r_din  <= INIT_VALUE;
                  r_cnt  <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_init_done <= 1'b1;
               if (|w_grant) begin
                  r_csb  <= 1'b0;
                  r_web  <= ~w_we;
                  r_addr <= w_addr;
                  r_din  <= w_wdata;
               end else begin
                  r_csb  <= 1'b1;
                  r_web  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign req_ready = w_grant;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign init_done = r_init_done;
   assign csb0      = r_csb;
   assign web0      = r_web;
   assign addr0     = r_addr;
   assign din0      = r_din;

endmodule
`default_nettype wire

// File: tb/tb_sram_rw_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_rw_port_arbiter
// Brief    : Bench for sram_rw_port_arbiter with a behavioural macro and a
//            transaction-level memory/response model.
// Revision : 1.0
// ============================================================================
module tb_sram_rw_port_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      int          due;
      int          req;
      logic [31:0] data;
   } rsp_t;

   logic clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   int cyc = 0;
   always @(posedge clk0) cyc <= cyc + 1;

   // ---------------- DUT with INIT enabled ----------------
   logic          rst0;
   logic [1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_rdata, din0;
   logic [DW-1:0] dout0;
   logic          init_done, csb0, web0;
   logic [AW-1:0] addr0;

   sram_rw_port_arbiter #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .INIT_EN (1'b1), .INIT_VALUE ('0)
   ) dut (
      .clk0 (clk0), .rst0 (rst0),
      .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
      .req_addr (req_addr), .req_wdata (req_wdata),
      .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .init_done (init_done),
      .csb0 (csb0), .web0 (web0), .addr0 (addr0), .din0 (din0), .dout0 (dout0)
   );

   // ---------------- DUT with INIT disabled ----------------
   logic          n_rst;
   logic [1:0]    n_valid, n_we, n_ready, n_rsp_valid;
   logic [2*AW-1:0] n_addr;
   logic [2*DW-1:0] n_wdata;
   logic [DW-1:0] n_rsp_rdata, n_din0, n_dout0;
   logic          n_init_done, n_csb0, n_web0;
   logic [AW-1:0] n_addr0;

   sram_rw_port_arbiter #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .INIT_EN (1'b0), .INIT_VALUE ('0)
   ) dut_ni (
      .clk0 (clk0), .rst0 (n_rst),
      .req_valid (n_valid), .req_ready (n_ready), .req_we (n_we),
      .req_addr (n_addr), .req_wdata (n_wdata),
      .rsp_valid (n_rsp_valid), .rsp_rdata (n_rsp_rdata), .init_done (n_init_done),
      .csb0 (n_csb0), .web0 (n_web0), .addr0 (n_addr0), .din0 (n_din0), .dout0 (n_dout0)
   );

   // ---------------- Behavioural macros: sample on rise, act on fall ----------------
   logic [DW-1:0] mem   [DEPTH];
   logic [DW-1:0] n_mem [DEPTH];
   logic m_csb = 1'b1, m_web = 1'b1, nm_csb = 1'b1, nm_web = 1'b1;
   logic [AW-1:0] m_addr, nm_addr;
   logic [DW-1:0] m_din, nm_din;

   always @(posedge clk0) begin
      m_csb  <= csb0;   m_web  <= web0;   m_addr  <= addr0;   m_din  <= din0;
      nm_csb <= n_csb0; nm_web <= n_web0; nm_addr <= n_addr0; nm_din <= n_din0;
   end

   always @(negedge clk0) begin
      if (m_csb === 1'b0) begin
         if (m_web === 1'b0) mem[m_addr] <= m_din;
         else                dout0 <= mem[m_addr];
      end
      if (nm_csb === 1'b0) begin
         if (nm_web === 1'b0) n_mem[nm_addr] <= nm_din;
         else                 n_dout0 <= n_mem[nm_addr];
      end
   end

   // ---------------- Reference model state ----------------
   int          errors = 0;
   int          checks = 0;
   bit          serve  = 1'b0;
   bit          ptr    = 1'b0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] exp_rdata = '0;
   rsp_t        q [$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      req_valid = v;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   task automatic check_rsp();
      logic [1:0] ev;
      ev = 2'b00;
      if (q.size() > 0 && q[0].due == cyc) begin
         ev        = 2'b01 << q[0].req;
         exp_rdata = q[0].data;
         void'(q.pop_front());
      end
      check("rsp_valid", rsp_valid, ev);
      check("rsp_rdata", rsp_rdata, exp_rdata);
   endtask

   // One SERVE-phase clock: predict the grant, then the macro pins and responses.
   task automatic serve_cycle();
      logic [1:0]    g;
      int            r;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          we;
      #1;
      g = 2'b00;
      if (serve && !rst0) begin
         if (req_valid == 2'b11) g = ptr ? 2'b10 : 2'b01;
         else                    g = req_valid;
      end
      check("req_ready", req_ready, g);
      r  = g[1] ? 1 : 0;
      a  = req_addr[r*AW +: AW];
      d  = req_wdata[r*DW +: DW];
      we = req_we[r];
      @(posedge clk0);
      #1;
      if (g != 2'b00) begin
         ptr = (r == 0);
         if (we) ref_mem[a] = d;
         else    q.push_back('{due: cyc + 2, req: r, data: ref_mem[a]});
         check("pins_access", {csb0, web0, addr0}, {1'b0, ~we, a});
         if (we) check("pins_din", din0, d);
      end else begin
         check("pins_idle", {csb0, web0}, 2'b11);
      end
      check_rsp();
   endtask

   // Called at #1 after the edge where reset was last sampled, with rst0 just lowered.
   task automatic init_seq();
      logic [AW-1:0] k_addr;
      serve = 1'b0;
      req_valid = 2'b11;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         check("init_ready", req_ready, 2'b00);
         @(posedge clk0);
         #1;
         k_addr = AW'(k);
         check("init_pin", {csb0, web0, addr0, din0, init_done, rsp_valid},
               {1'b0, 1'b0, k_addr, 32'h0, 1'b0, 2'b00});
      end
      #1;
      check("init_ready_last", req_ready, 2'b00);
      @(posedge clk0);
      #1;
      check("init_done_rise", {init_done, csb0, web0}, 3'b111);
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
      serve = 1'b1;
      ptr   = 1'b0;
      req_valid = 2'b00;
   endtask

   initial begin
      rst0  = 1'b1;
      n_rst = 1'b1;
      drive(2'b11, 2'b00, '0, '0, '0, '0);
      n_valid = 2'b00; n_we = 2'b00; n_addr = '0; n_wdata = '0;
      repeat (3) @(posedge clk0);
      #1;
      check("reset_state", {csb0, web0, addr0, din0, req_ready, rsp_valid, rsp_rdata, init_done},
            {1'b1, 1'b1, 10'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0});
      check("reset_state_ni", {n_csb0, n_web0, n_addr0, n_din0, n_rsp_valid, n_rsp_rdata, n_init_done},
            {1'b1, 1'b1, 10'h0, 32'h0, 2'b00, 32'h0, 1'b0});

      // Full-array clear with both requesters asking the whole time.
      rst0 = 1'b0;
      init_seq();

      // Write then immediately read back through requester 0.
      drive(2'b01, 2'b01, 10'd5, '0, 32'hDEADBEEF, '0); serve_cycle();
      drive(2'b01, 2'b00, 10'd5, '0, '0, '0);           serve_cycle();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      repeat (3) serve_cycle();

      // Top address after clear, via requester 1.
      drive(2'b10, 2'b00, '0, 10'd1023, '0, '0); serve_cycle();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      repeat (3) serve_cycle();

      // Both requesters stream reads.
      drive(2'b01, 2'b01, 10'd10, '0, 32'hA5A5_0010, '0); serve_cycle();
      drive(2'b10, 2'b10, '0, 10'd20, '0, 32'h5A5A_0020); serve_cycle();
      drive(2'b11, 2'b00, 10'd10, 10'd20, '0, '0);
      repeat (8) serve_cycle();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      repeat (3) serve_cycle();

      // Random traffic over a small address window so reads hit prior writes.
      for (int n = 0; n < 300; n++) begin
         drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
               DW'($urandom), DW'($urandom));
         serve_cycle();
      end
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      repeat (3) serve_cycle();
      check("queue_drained", q.size(), 0);

      // Reset right after a read accept: the read is dropped and INIT restarts.
      drive(2'b01, 2'b00, 10'd10, '0, '0, '0); serve_cycle();
      rst0 = 1'b1;
      req_valid = 2'b11;
      #1;
      check("rst_ready", req_ready, 2'b00);
      @(posedge clk0);
      #1;
      check("rst_pins", {csb0, web0, rsp_valid, init_done}, {1'b1, 1'b1, 2'b00, 1'b0});
      q.delete();
      exp_rdata = '0;
      rst0 = 1'b0;
      init_seq();
      drive(2'b10, 2'b00, '0, 10'd10, '0, '0); serve_cycle();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      repeat (3) serve_cycle();

      // INIT disabled: serving starts at the first edge after release.
      n_valid = 2'b01; n_we = 2'b01; n_addr = {10'd0, 10'd3}; n_wdata = {32'h0, 32'h1234_5678};
      n_rst = 1'b0;
      #1;
      check("ni_ready", n_ready, 2'b01);
      @(posedge clk0);
      #1;
      check("ni_first_edge", {n_init_done, n_csb0, n_web0, n_addr0, n_din0},
            {1'b1, 1'b0, 1'b0, 10'd3, 32'h1234_5678});
      n_we = 2'b00;
      #1;
      check("ni_read_ready", n_ready, 2'b01);
      @(posedge clk0);
      #1;
      check("ni_read_pins", {n_csb0, n_web0, n_addr0}, {1'b0, 1'b1, 10'd3});
      n_valid = 2'b00;
      @(posedge clk0);
      #1;
      check("ni_rsp_wait", n_rsp_valid, 2'b00);
      @(posedge clk0);
      #1;
      check("ni_rsp", {n_rsp_valid, n_rsp_rdata}, {2'b01, 32'h1234_5678});
      @(posedge clk0);
      #1;
      check("ni_rsp_hold", {n_rsp_valid, n_rsp_rdata}, {2'b00, 32'h1234_5678});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_rw_port_arbiter.md
Name: sram_rw_port_arbiter

Overview:
Controller in front of one single-port RW OpenRAM macro: 32-bit words, 1024 deep, active-low csb0/web0, inputs registered on rising clk0, access completed on falling clk0.
- After reset, sequences a full-array clear (INIT).
- Then shares the single port between two requesters using round-robin arbitration with a valid/ready handshake.
- Returns read data with fixed latency.
- Sits between the macro instance and the core-side masters.

Parameters:
DATA_WIDTH, 32, macro word width
ADDR_WIDTH, 10, macro address width; RAM_DEPTH = 1<<ADDR_WIDTH
INIT_EN, 1, 1 = clear the whole array after every reset; 0 = skip INIT
INIT_VALUE, 0, word written to every address during INIT

Ports:
clk0  input  1  clock; shared with the macro clk0
rst0  input  1  synchronous active-high reset
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester grant/accept
req_we  input  2  1 = write, 0 = read, per requester
req_addr  input  2*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  2*DATA_WIDTH  packed write data
rsp_valid  output  2  one-cycle read-response strobe, per requester
rsp_rdata  output  DATA_WIDTH  shared read data, qualified by rsp_valid
init_done  output  1  high once INIT is complete; stays high until reset
csb0  output  1  macro chip select, active low
web0  output  1  macro write enable, active low
addr0  output  ADDR_WIDTH  macro address
din0  output  DATA_WIDTH  macro write data
dout0  input  DATA_WIDTH  macro read data

Behaviour:
- Clock/reset: one clock clk0; reset rst0 is synchronous, active-high.
- Reset values: csb0=1, web0=1, addr0=0, din0=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, RR pointer=0 (requester 0 favoured).
- Reset state is INIT when INIT_EN=1, otherwise SERVE.
- Macro pins (csb0/web0/addr0/din0) are all registered; an idle cycle drives csb0=1, web0=1.

INIT:
- A counter runs 0..RAM_DEPTH-1.
- Address k is presented as a write (csb0=0, web0=0, din0=INIT_VALUE) in cycle k+1 after reset release.
- req_ready=0 throughout.
- init_done is set at the edge after address RAM_DEPTH-1 is presented (RAM_DEPTH+1 edges after release); the state moves to SERVE at the same edge.

SERVE:
- req_ready is combinational, at most one-hot, and depends on req_valid.
- Both valid: grant the requester selected by the RR pointer.
- One valid: grant it.
- On any grant, the pointer moves to the other requester.
- Throughput: one access per cycle, no bubbles.

Timing for a request accepted at edge E (valid && ready):
- Macro pins carry the access during E..E+1; the macro samples at E+1 and writes/reads at the following falling edge.
- Read: rsp_rdata is loaded from dout0 at edge E+2, and rsp_valid[i] is high for exactly that one cycle. Fixed latency: 2 edges.
- Write: produces no response.

Ordering and data rules:
- Accesses complete in acceptance order.
- A write at E followed by a read of the same address at E+1 returns the new data.
- At most one rsp_valid bit is high per cycle.
- rsp_rdata holds its value when no response is pending.
- Back-to-back reads from either or both requesters pipeline fully.

Reset mid-operation:
- In-flight reads are dropped and no rsp_valid is issued.
- csb0=1 the cycle after reset is sampled.
- INIT restarts at address 0. With INIT_EN=0, array contents are untouched.

Decomposition:
- Package sram_ctrl_pkg: DATA_WIDTH/ADDR_WIDTH defaults, NUM_REQ=2, state enum {INIT, SERVE}, READ_LATENCY=2.
- Sub-module rr_arbiter_2: combinational 2-way round-robin grant plus a registered pointer that advances on accept.

Test Plan:
1. Release reset with INIT_EN=1:
   - Expect 1024 consecutive write cycles, addr0 = 0..1023, din0=0.
   - init_done rises 1025 edges after release.
   - req_ready=0 throughout, even with req_valid=2'b11.
2. After INIT, requester 0 writes 0xDEADBEEF to address 5, then reads address 5 on the next cycle:
   - rsp_valid[0] is high exactly 2 edges after read acceptance.
   - rsp_rdata = 0xDEADBEEF.
3. Read address 1023 via requester 1 after INIT -> rsp_valid[1] with rsp_rdata = 0x00000000.
4. Both requesters hold valid continuously, reading addresses 10 and 20:
   - Grants alternate 0,1,0,1 starting with 0.
   - rsp_valid alternates [0],[1] with matching data.
   - No idle cycles on csb0.
5. Assert rst0 the cycle after a read accept -> no rsp_valid, csb0=1 next cycle, INIT restarts at addr0=0.
6. INIT_EN=0 -> init_done and the SERVE state are active the first edge after release, and a write at address 3 is presented on the next cycle.
